// File: rtl/chirp_sweep_ctrl_pkg.sv
// Shared definitions for the chirp sweep sequencer: default widths, FSM
// encoding and the two's-complement helper used for the down-ramp increment.
package chirp_sweep_ctrl_pkg;

    localparam int N_DEF     = 32;
    localparam int FRAC_DEF  = 32;
    localparam int LW_DEF    = 24;
    localparam int RW_DEF    = 16;
    localparam int ACC_W_MAX = N_DEF + FRAC_DEF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SWEEP = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Negation mod 2^ACC_W_MAX; callers keep the low bits they need.
    function automatic logic [ACC_W_MAX-1:0] neg_delta(input logic [ACC_W_MAX-1:0] d);
        return ~d + 1'b1;
    endfunction

endpackage

// File: rtl/chirp_sweep_ctrl_if.sv
// Control/config handshake between the register block (master) and the
// chirp sweep sequencer (slave), including the freq_acc drive signals.
interface chirp_sweep_ctrl_if #(
    parameter int N    = chirp_sweep_ctrl_pkg::N_DEF,
    parameter int FRAC = chirp_sweep_ctrl_pkg::FRAC_DEF,
    parameter int LW   = chirp_sweep_ctrl_pkg::LW_DEF,
    parameter int RW   = chirp_sweep_ctrl_pkg::RW_DEF
);

    logic                start;
    logic                abort;
    logic [N-1:0]        cfg_ftw0;
    logic [N+FRAC-1:0]   cfg_delta;
    logic [LW-1:0]       cfg_len;
    logic [LW-1:0]       cfg_gap;
    logic [RW-1:0]       cfg_nrep;
    logic                cfg_tri;

    logic                acc_load;
    logic [N+FRAC-1:0]   ftw0_acc;
    logic [N+FRAC-1:0]   delta_acc;
    logic                busy;
    logic                chirp_sync;
    logic                ramp_down;
    logic                done;

    modport master (
        output start, abort, cfg_ftw0, cfg_delta, cfg_len, cfg_gap, cfg_nrep, cfg_tri,
        input  acc_load, ftw0_acc, delta_acc, busy, chirp_sync, ramp_down, done
    );

    modport slave (
        input  start, abort, cfg_ftw0, cfg_delta, cfg_len, cfg_gap, cfg_nrep, cfg_tri,
        output acc_load, ftw0_acc, delta_acc, busy, chirp_sync, ramp_down, done
    );

endinterface

// File: rtl/chirp_sweep_ctrl_len_counter.sv
// Up-counter with clear and terminal-count compare; used for both the ramp
// length and the inter-chirp gap.
module chirp_sweep_ctrl_len_counter
    import chirp_sweep_ctrl_pkg::*;
#(
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [LW-1:0] term,
    output logic          tc
);

    logic [LW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/chirp_sweep_ctrl.sv
// Chirp sweep sequencer: latches a sweep config on start and drives the
// freq_acc load/delta inputs through up/down ramps, gaps and repeats.
module chirp_sweep_ctrl
    import chirp_sweep_ctrl_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int LW   = LW_DEF,
    parameter int RW   = RW_DEF
) (
    input logic               clk,
    input logic               rst,
    chirp_sweep_ctrl_if.slave bus
);

    localparam int AW = N + FRAC;

    state_t        state_q, state_n;
    logic          acc_load_q, acc_load_n;
    logic [AW-1:0] ftw0_q, ftw0_n;
    logic [AW-1:0] delta_q, delta_n;
    logic          busy_q, busy_n;
    logic          sync_q, sync_n;
    logic          ramp_down_q, ramp_down_n;
    logic          done_q, done_n;
    logic [RW-1:0] rep_q, rep_n;

    logic [AW-1:0] delta_lat;
    logic [LW-1:0] len_lat, gap_lat;
    logic [RW-1:0] nrep_lat;
    logic          tri_lat;
    logic          latch;

    logic          len_clr, len_inc, len_tc;
    logic          gap_clr, gap_inc, gap_tc;
    logic [LW-1:0] len_term, gap_term;

    logic [ACC_W_MAX-1:0] delta_neg_full;
    logic [AW-1:0]        delta_neg;
    logic [RW:0]          rep_inc;

    // Continuous runs keep counting chirps; pin at all-ones instead of wrapping.
    function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign delta_neg_full = neg_delta(ACC_W_MAX'(delta_lat));
    assign delta_neg      = delta_neg_full[AW-1:0];
    assign rep_inc        = {1'b0, rep_q} + 1'b1;
    assign len_term       = len_lat - 1'b1;
    assign gap_term       = gap_lat - 1'b1;

    chirp_sweep_ctrl_len_counter #(.LW(LW)) u_len_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (len_clr),
        .inc  (len_inc),
        .term (len_term),
        .tc   (len_tc)
    );

    chirp_sweep_ctrl_len_counter #(.LW(LW)) u_gap_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (gap_clr),
        .inc  (gap_inc),
        .term (gap_term),
        .tc   (gap_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delta_lat <= '0;
            len_lat   <= '0;
            gap_lat   <= '0;
            nrep_lat  <= '0;
            tri_lat   <= 1'b0;
        end else if (latch) begin
            delta_lat <= bus.cfg_delta;
            len_lat   <= (bus.cfg_len == '0) ? LW'(1) : bus.cfg_len;
            gap_lat   <= bus.cfg_gap;
            nrep_lat  <= bus.cfg_nrep;
            tri_lat   <= bus.cfg_tri;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_load_q  <= 1'b1;
            ftw0_q      <= '0;
            delta_q     <= '0;
            busy_q      <= 1'b0;
            sync_q      <= 1'b0;
            ramp_down_q <= 1'b0;
            done_q      <= 1'b0;
            rep_q       <= '0;
        end else begin
            state_q     <= state_n;
            acc_load_q  <= acc_load_n;
            ftw0_q      <= ftw0_n;
            delta_q     <= delta_n;
            busy_q      <= busy_n;
            sync_q      <= sync_n;
            ramp_down_q <= ramp_down_n;
            done_q      <= done_n;
            rep_q       <= rep_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        acc_load_n  = 1'b1;
        ftw0_n      = ftw0_q;
        delta_n     = delta_q;
        busy_n      = 1'b0;
        sync_n      = 1'b0;
        ramp_down_n = 1'b0;
        done_n      = 1'b0;
        rep_n       = rep_q;
        latch       = 1'b0;
        len_clr     = 1'b0;
        len_inc     = 1'b0;
        gap_clr     = 1'b0;
        gap_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    latch   = 1'b1;
                    state_n = ST_LOAD;
                    busy_n  = 1'b1;
                    ftw0_n  = {bus.cfg_ftw0, {FRAC{1'b0}}};
                    delta_n = bus.cfg_delta;
                    rep_n   = '0;
                    len_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                state_n    = ST_SWEEP;
                acc_load_n = 1'b0;
                busy_n     = 1'b1;
                sync_n     = 1'b1;
                len_clr    = 1'b1;
            end
            ST_SWEEP: begin
                busy_n      = 1'b1;
                acc_load_n  = 1'b0;
                ramp_down_n = ramp_down_q;
                if (!len_tc) begin
                    len_inc = 1'b1;
                end else if (tri_lat && !ramp_down_q) begin
                    // Turnaround: keep accumulating from the top value, no reload.
                    ramp_down_n = 1'b1;
                    delta_n     = delta_neg;
                    len_clr     = 1'b1;
                end else begin
                    rep_n       = sat_inc(rep_q);
                    acc_load_n  = 1'b1;
                    ramp_down_n = 1'b0;
                    if ((nrep_lat != '0) && (rep_inc == {1'b0, nrep_lat})) begin
                        state_n = ST_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else if (gap_lat != '0) begin
                        state_n = ST_GAP;
                        gap_clr = 1'b1;
                    end else begin
                        state_n = ST_LOAD;
                        delta_n = delta_lat;
                        len_clr = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                busy_n  = 1'b1;
                gap_inc = 1'b1;
                if (gap_tc) begin
                    state_n = ST_LOAD;
                    delta_n = delta_lat;
                    len_clr = 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a same-cycle start or terminal count.
        if (bus.abort) begin
            state_n     = ST_IDLE;
            acc_load_n  = 1'b1;
            ftw0_n      = ftw0_q;
            delta_n     = delta_q;
            busy_n      = 1'b0;
            sync_n      = 1'b0;
            ramp_down_n = 1'b0;
            done_n      = 1'b0;
            rep_n       = rep_q;
            latch       = 1'b0;
        end
    end

    assign bus.acc_load   = acc_load_q;
    assign bus.ftw0_acc   = ftw0_q;
    assign bus.delta_acc  = delta_q;
    assign bus.busy       = busy_q;
    assign bus.chirp_sync = sync_q;
    assign bus.ramp_down  = ramp_down_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_chirp_sweep_ctrl.sv
// Bench for chirp_sweep_ctrl: directed and randomized sweeps compared cycle by
// cycle against an expected-output trace expanded from the sweep config.
module tb_chirp_sweep_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chirp_sweep_ctrl_if bus ();

    chirp_sweep_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Downstream freq_acc: one-cycle lag from acc_load/delta_acc to ftw_out.
    logic [63:0] acc;
    logic [31:0] ftw_out;
    always_ff @(posedge clk) acc <= bus.acc_load ? bus.ftw0_acc : acc + bus.delta_acc;
    assign ftw_out = acc[63:32];

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        load, busy, sync, rdown, done;
        logic        chk_delta, chk_ftw, chk_ftw0;
        logic [63:0] delta;
        logic [31:0] ftw;
        logic [63:0] ftw0;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_entry(input string name, input int k, input exp_t e);
        chk($sformatf("%s.acc_load[%0d]", name, k), 64'(bus.acc_load), 64'(e.load));
        chk($sformatf("%s.busy[%0d]", name, k), 64'(bus.busy), 64'(e.busy));
        chk($sformatf("%s.chirp_sync[%0d]", name, k), 64'(bus.chirp_sync), 64'(e.sync));
        chk($sformatf("%s.ramp_down[%0d]", name, k), 64'(bus.ramp_down), 64'(e.rdown));
        chk($sformatf("%s.done[%0d]", name, k), 64'(bus.done), 64'(e.done));
        if (e.chk_delta) chk($sformatf("%s.delta_acc[%0d]", name, k), bus.delta_acc, e.delta);
        if (e.chk_ftw0)  chk($sformatf("%s.ftw0_acc[%0d]", name, k), bus.ftw0_acc, e.ftw0);
        if (e.chk_ftw)   chk($sformatf("%s.ftw_out[%0d]", name, k), 64'(ftw_out), 64'(e.ftw));
    endtask

    task automatic check_idle(input string name);
        chk({name, ".idle.acc_load"}, 64'(bus.acc_load), 64'd1);
        chk({name, ".idle.busy"}, 64'(bus.busy), 64'd0);
        chk({name, ".idle.chirp_sync"}, 64'(bus.chirp_sync), 64'd0);
        chk({name, ".idle.ramp_down"}, 64'(bus.ramp_down), 64'd0);
        chk({name, ".idle.done"}, 64'(bus.done), 64'd0);
    endtask

    task automatic check_reset(input string name);
        check_idle(name);
        chk({name, ".ftw0_acc"}, bus.ftw0_acc, 64'd0);
        chk({name, ".delta_acc"}, bus.delta_acc, 64'd0);
    endtask

    // Expected per-cycle outputs from the cycle after start, as a flat sequence
    // of chirps: load, up samples, optional down samples, then gap or done.
    task automatic build(input logic [31:0] ftw0, input logic [63:0] delta,
                         input int len, input int gap, input int nrep,
                         input int tri_en, input int ncont);
        int          l, nch;
        logic [63:0] base, a;
        exp_t        e;
        q.delete();
        l    = (len == 0) ? 1 : len;
        nch  = (nrep == 0) ? ncont : nrep;
        base = {ftw0, 32'd0};
        for (int c = 0; c < nch; c++) begin
            e = '{default: '0};
            e.load = 1'b1; e.busy = 1'b1;
            e.chk_delta = 1'b1; e.delta = delta;
            e.chk_ftw0 = 1'b1; e.ftw0 = base;
            q.push_back(e);
            for (int i = 0; i < l; i++) begin
                e = '{default: '0};
                e.busy = 1'b1; e.sync = (i == 0);
                e.chk_delta = 1'b1; e.delta = delta;
                a = base + 64'(i) * delta;
                e.chk_ftw = 1'b1; e.ftw = a[63:32];
                q.push_back(e);
            end
            if (tri_en != 0) begin
                for (int j = 0; j < l; j++) begin
                    e = '{default: '0};
                    e.busy = 1'b1; e.rdown = 1'b1;
                    e.chk_delta = 1'b1; e.delta = 64'd0 - delta;
                    a = base + 64'(l) * delta - 64'(j) * delta;
                    e.chk_ftw = 1'b1; e.ftw = a[63:32];
                    q.push_back(e);
                end
            end
            if (nrep != 0 && c == nch - 1) begin
                e = '{default: '0};
                e.load = 1'b1; e.done = 1'b1;
                q.push_back(e);
            end else begin
                for (int g = 0; g < gap; g++) begin
                    e = '{default: '0};
                    e.load = 1'b1; e.busy = 1'b1;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic run(input string name, input logic [31:0] ftw0, input logic [63:0] delta,
                       input int len, input int gap, input int nrep, input int tri_en,
                       input int ncont, input int abort_at, input int busy_start_at);
        build(ftw0, delta, len, gap, nrep, tri_en, ncont);
        @(negedge clk);
        bus.cfg_ftw0  = ftw0;
        bus.cfg_delta = delta;
        bus.cfg_len   = 24'(len);
        bus.cfg_gap   = 24'(gap);
        bus.cfg_nrep  = 16'(nrep);
        bus.cfg_tri   = (tri_en != 0);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            if (k > 0) @(negedge clk);
            check_entry(name, k, q[k]);
            bus.start = 1'b0;
            if (k == busy_start_at) begin
                bus.cfg_ftw0  = ~ftw0;
                bus.cfg_delta = ~delta;
                bus.cfg_len   = 24'(len + 3);
                bus.cfg_gap   = 24'(gap + 1);
                bus.cfg_tri   = (tri_en == 0);
                bus.start     = 1'b1;
            end
            if (k == abort_at) begin
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                check_idle({name, ".abort"});
                @(negedge clk);
                check_idle({name, ".abort+1"});
                return;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check_idle({name, ".end"});
    endtask

    initial begin
        logic [31:0] r_ftw0;
        logic [63:0] r_delta;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.cfg_ftw0  = '0;
        bus.cfg_delta = '0;
        bus.cfg_len   = '0;
        bus.cfg_gap   = '0;
        bus.cfg_nrep  = '0;
        bus.cfg_tri   = 1'b0;

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset("post_reset");

        run("T1_up", 32'd100, 64'h1_0000_0000, 4, 0, 1, 0, 0, -1, -1);
        run("T2_tri", 32'd100, 64'h1_0000_0000, 4, 0, 1, 1, 0, -1, -1);
        run("T3_gap", 32'd100, 64'h1_0000_0000, 3, 2, 3, 0, 0, -1, 6);
        run("T4_cont", 32'd100, 64'h1_0000_0000, 5, 0, 0, 0, 12, 69, -1);
        run("T4_abort_tc", 32'd100, 64'h1_0000_0000, 4, 0, 1, 0, 0, 4, -1);
        run("T5_len0", 32'd7, 64'h0_8000_0000, 0, 0, 2, 0, 0, -1, 1);
        run("T5_tri_gap", 32'hFFFF_FFFE, 64'h3_0000_0000, 2, 1, 2, 1, 0, -1, 2);

        // Start and abort in the same idle cycle: nothing must begin.
        @(negedge clk);
        bus.cfg_len = 24'd3; bus.cfg_nrep = 16'd1;
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check_idle("T5_start_abort");
        @(negedge clk);
        check_idle("T5_start_abort+1");

        // Async reset between clock edges during a sweep.
        build(32'd100, 64'h1_0000_0000, 4, 0, 1, 0, 0);
        bus.cfg_ftw0 = 32'd555; bus.cfg_delta = 64'h2_0000_0000;
        bus.cfg_len = 24'd8; bus.cfg_gap = 24'd0; bus.cfg_nrep = 16'd1; bus.cfg_tri = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("T6.pre_rst_busy", 64'(bus.busy), 64'd1);
        #2 rst = 1'b1;
        #1 check_reset("T6.async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("T6.released");
        run("T6_T1", 32'd100, 64'h1_0000_0000, 4, 0, 1, 0, 0, -1, -1);

        for (int n = 0; n < 6; n++) begin
            r_ftw0  = $urandom;
            r_delta = {$urandom, $urandom};
            run($sformatf("R%0d", n), r_ftw0, r_delta,
                int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 3)), int'($urandom_range(0, 1)), 0, -1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
